// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF/ID queue
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc_plus4;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc_plus4;
    logic              id_is_ctrl;

    // Pipeline side: fetch offers entries, decode consumes them
    modport master (
        output if_valid, if_pc, if_instr, if_pc_plus4, id_ready,
        input  if_ready, id_valid, id_pc, id_instr, id_pc_plus4, id_is_ctrl
    );

    // Queue side
    modport slave (
        input  if_valid, if_pc, if_instr, if_pc_plus4, id_ready,
        output if_ready, id_valid, id_pc, id_instr, id_pc_plus4, id_is_ctrl
    );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular FIFO decoupling fetch from decode with redirect flush
module if_id_queue #(
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 32,
    parameter int              DEPTH  = 2,
    parameter logic [DATA_W-1:0] NOP  = 32'h0000_0013,
    localparam int             PTR_W  = $clog2(DEPTH),
    localparam int             CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    if_id_queue_if.slave       bus,
    output logic [CNT_W-1:0]   count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] plus4_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic [DATA_W-1:0] head_instr;

    // if_ready looks only at occupancy so decode back-pressure never reaches fetch combinationally
    assign bus.if_ready = (count < DEPTH_C);
    assign not_empty    = (count != '0);
    assign bus.id_valid = not_empty;

    assign push = bus.if_valid & bus.if_ready & ~flush;
    assign pop  = not_empty & bus.id_ready & ~flush;

    assign head_instr      = instr_mem[rd_ptr];
    assign bus.id_pc       = not_empty ? pc_mem[rd_ptr]    : '0;
    assign bus.id_pc_plus4 = not_empty ? plus4_mem[rd_ptr] : '0;
    assign bus.id_instr    = not_empty ? head_instr        : NOP;

    // jal, jalr and branch opcodes mark the head as a control-flow instruction
    assign bus.id_is_ctrl = not_empty &&
                            ((head_instr[6:0] == 7'b1101111) ||
                             (head_instr[6:0] == 7'b1100111) ||
                             (head_instr[6:0] == 7'b1100011));

    // Entry storage: written on accepted pushes only, contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.if_pc;
            instr_mem[wr_ptr] <= bus.if_instr;
            plus4_mem[wr_ptr] <= bus.if_pc_plus4;
        end
    end

    // Pointers and occupancy; flush discards everything including this cycle's push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C)
        else $error("if_id_queue occupancy exceeded DEPTH");

endmodule
